// File: rtl/rtc_bus_ctrl.sv
// RTC parallel-bus responder: runs one multiplexed address/data transaction per request
// and performs the two-write RTC initialisation sequence after reset.
module rtc_bus_ctrl #(
    parameter int unsigned T_STB    = 4,
    parameter int unsigned T_GAP    = 2,
    parameter logic [7:0]  INIT_REG = 8'h02,
    parameter logic [7:0]  INIT_V1  = 8'h10,
    parameter logic [7:0]  INIT_V2  = 8'h00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Acceso,
    input  logic [7:0] Dir,
    input  logic       Mod,
    input  logic [7:0] Dato_wr,
    input  logic [7:0] ADbus_in,
    output logic       FRW,
    output logic [7:0] Dato_rd,
    output logic       Busy,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       AD,
    output logic [7:0] ADbus_out,
    output logic       ADbus_oe
);

    localparam int unsigned CNT_MAX = (T_STB > T_GAP) ? T_STB : T_GAP;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] STB_LAST = CW'(T_STB - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(T_GAP - 1);

    typedef enum logic [2:0] {
        S_INIT1, S_INIT2, S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        STEP_USER, STEP_INIT1, STEP_INIT2
    } step_t;

    state_t        state_q, state_d;
    step_t         step_q, step_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    d_q, d_d;
    logic          w_q, w_d;
    logic [7:0]    dato_rd_q, dato_rd_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_INIT1;
            step_q    <= STEP_USER;
            cnt_q     <= '0;
            a_q       <= '0;
            d_q       <= '0;
            w_q       <= 1'b0;
            dato_rd_q <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            d_q       <= d_d;
            w_q       <= w_d;
            dato_rd_q <= dato_rd_d;
        end
    end

    // Bus outputs are decoded from the registered state, so an asynchronous reset
    // releases the strobes and the bus in the same cycle.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        d_d       = d_q;
        w_d       = w_q;
        dato_rd_d = dato_rd_q;
        CS_n      = 1'b1;
        RD_n      = 1'b1;
        WR_n      = 1'b1;
        AD        = 1'b0;
        ADbus_out = '0;
        ADbus_oe  = 1'b0;
        FRW       = 1'b0;

        case (state_q)
            S_INIT1: begin
                a_d     = INIT_REG;
                d_d     = INIT_V1;
                w_d     = 1'b1;
                step_d  = STEP_INIT1;
                cnt_d   = '0;
                state_d = S_ADDR;
            end
            S_INIT2: begin
                a_d     = INIT_REG;
                d_d     = INIT_V2;
                w_d     = 1'b1;
                step_d  = STEP_INIT2;
                cnt_d   = '0;
                state_d = S_ADDR;
            end
            S_IDLE: begin
                if (Acceso) begin
                    a_d     = Dir;
                    d_d     = Dato_wr;
                    w_d     = Mod;
                    step_d  = STEP_USER;
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                CS_n      = 1'b0;
                WR_n      = 1'b0;
                ADbus_oe  = 1'b1;
                ADbus_out = a_q;
                if (cnt_q == STB_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP1: begin
                AD = 1'b1;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                CS_n = 1'b0;
                AD   = 1'b1;
                if (w_q) begin
                    WR_n      = 1'b0;
                    ADbus_oe  = 1'b1;
                    ADbus_out = d_q;
                end else begin
                    RD_n = 1'b0;
                end
                if (cnt_q == STB_LAST) begin
                    if (!w_q) dato_rd_d = ADbus_in;
                    cnt_d   = '0;
                    state_d = S_GAP2;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP2: begin
                AD = 1'b1;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                FRW     = 1'b1;
                cnt_d   = '0;
                state_d = (step_q == STEP_INIT1) ? S_INIT2 : S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_INIT1;
            end
        endcase
    end

    assign Busy    = (state_q != S_IDLE);
    assign Dato_rd = dato_rd_q;

endmodule

// File: doc/rtc_bus_ctrl.md
Name: rtc_bus_ctrl

Overview:
Bus-side responder for the menu/scan FSM. It accepts access requests (`Acceso`, `Dir`, `Mod`, `Dato_wr`) and executes one multiplexed-address/data transaction on the RTC parallel bus (Intel-style: `CS_n`, `RD_n`, `WR_n`, `AD` select, 8-bit AD bus). On completion it returns a one-cycle `FRW` pulse. After reset it runs the RTC initialisation sequence on its own, emitting one `FRW` pulse per init write. Bidirectional pad/tristate logic lives at top level; this block exposes split in/out/oe.

Parameters:
- `T_STB`, 4, strobe-low width in `CLK` cycles for both address and data phases (≥1)
- `T_GAP`, 2, cycles with `CS_n`/`RD_n`/`WR_n` all high between phases and after the data phase (≥1)
- `INIT_REG`, 8'h02, register written during initialisation
- `INIT_V1`, 8'h10, first init value (init bit set)
- `INIT_V2`, 8'h00, second init value (init bit cleared)

Ports:
- `CLK` in 1: system clock
- `RST` in 1: asynchronous, active-high reset
- `Acceso` in 1: access request, level, sampled only in IDLE
- `Dir` in 8: RTC register address
- `Mod` in 1: 1 = write, 0 = read
- `Dato_wr` in 8: write data
- `ADbus_in` in 8: AD bus value read from pads
- `FRW` out 1: transaction finished, one-cycle pulse
- `Dato_rd` out 8: last read data
- `Busy` out 1: high whenever the FSM is not in IDLE
- `CS_n` out 1: chip select, active low
- `RD_n` out 1: read strobe, active low
- `WR_n` out 1: write strobe, active low
- `AD` out 1: 0 = address phase, 1 = data phase
- `ADbus_out` out 8: value driven onto AD bus
- `ADbus_oe` out 1: AD bus output enable

Behaviour:
Reset (asynchronous; takes effect immediately, including mid-transaction):
- `CS_n`, `RD_n`, `WR_n` = 1; `AD` = 0; `ADbus_oe` = 0; `ADbus_out` = 0; `Dato_rd` = 0; `FRW` = 0; `Busy` = 1.
- FSM goes to INIT1; strobe counter = 0.

States: INIT1, INIT2, IDLE, ADDR, GAP1, DATA, GAP2, DONE.

Transaction registers:
- `a_reg`, `d_reg`, `w_reg` are latched at acceptance. Input changes after that are ignored.

Acceptance:
- In IDLE with `Acceso` = 1: latch `Dir`, `Dato_wr`, `Mod`, and go to ADDR next cycle.
- `Acceso` is ignored in every other state; there is no queueing.

ADDR (`T_STB` cycles):
- `CS_n` = 0, `WR_n` = 0, `RD_n` = 1, `AD` = 0, `ADbus_oe` = 1, `ADbus_out` = `a_reg`.

GAP1 (`T_GAP` cycles):
- `CS_n` = `RD_n` = `WR_n` = 1, `ADbus_oe` = 0, `AD` = 1.

DATA (`T_STB` cycles):
- `CS_n` = 0, `AD` = 1.
- Write: `WR_n` = 0, `ADbus_oe` = 1, `ADbus_out` = `d_reg`.
- Read: `RD_n` = 0, `ADbus_oe` = 0. On the last DATA cycle, `Dato_rd` <= `ADbus_in`.
- `Dato_rd` is unchanged on writes.

GAP2 (`T_GAP` cycles):
- All strobes high, `ADbus_oe` = 0.

DONE (1 cycle):
- `FRW` = 1, then back to IDLE. From IDLE, the next acceptance can happen in the cycle after DONE.

Latency:
- With acceptance at cycle 0, `FRW` is high at cycle 1 + 2·`T_STB` + 2·`T_GAP` (13 with defaults).
- `Dato_rd` is valid no later than the `FRW` cycle and holds until the next read.

Init:
- INIT1 runs a full write cycle (`INIT_REG` ← `INIT_V1`), including DONE/`FRW`, then enters INIT2.
- INIT2 runs a write of `INIT_V2` to `INIT_REG` with its own `FRW` pulse, then enters IDLE.
- Exactly two `FRW` pulses occur before the first user transaction. `Acceso` is ignored until IDLE.
- Implementation: INIT states reuse the ADDR..DONE path with an init-step register selecting the return state.

Mutual-exclusion invariants (must hold every cycle):
- `RD_n` and `WR_n` are never both 0.
- No strobe is low while `CS_n` = 1.
- `ADbus_oe` = 0 whenever `RD_n` = 0.
- `AD` changes only while `CS_n` = 1 or at a phase boundary entered from GAP.

Counters:
- The strobe/gap counter is wide enough for max(`T_STB`, `T_GAP`).
- It clears on every state entry; no wrap-around is possible.

Test Plan:
- Release `RST`, `Acceso` = 0 → two full write cycles to addr 0x02 with data 0x10 then 0x00. `FRW` pulses exactly twice, then `Busy` = 0.
- After init: `Acceso` = 1 (held 8 cycles), `Dir` = 0x21, `Mod` = 0, `ADbus_in` = 0x45 during DATA → `ADbus_out` = 0x21 in ADDR, `RD_n` low 4 cycles, `Dato_rd` = 0x45, `FRW` at acceptance + 13, one cycle wide.
- Write: `Dir` = 0x41, `Dato_wr` = 0x30, `Mod` = 1 → `WR_n` low in ADDR (bus 0x41) and in DATA (bus 0x30); `Dato_rd` unchanged; no read strobe.
- Change `Dir`/`Dato_wr` and pulse `Acceso` again mid-transaction → bus shows the originally latched values, only one `FRW`, and the second request is not executed.
- Back-to-back scan 0x21..0x27 plus 0xF0, with `Acceso` re-asserted 3 cycles after each `FRW` → 8 transactions with correct addresses and invariants holding throughout.
- Assert `RST` during DATA of a write → same cycle: strobes high, `ADbus_oe` = 0; after release the init sequence restarts (two `FRW` pulses).
